i2c_cmd_scheduler: RTL and testbench
====================================

I2C_CMD_SCHEDULER -- requirements
Module: i2c_cmd_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYC, 4000000, clk cycles allowed in WAIT before the transaction is aborted (20 ms at 200 MHz).
REQ-002 Parameter CMD_W, 24, command width: {dev_addr[7:1], rw[0]} in [23:16], reg_addr in [15:8], wdata in [7:0].
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 wr_req_valid / wr_req_ready / wr_req_cmd  in/out/in  1/1/CMD_W  write-requester command handshake.
REQ-006 rd_req_valid / rd_req_ready / rd_req_cmd  in/out/in  1/1/CMD_W  read-requester command handshake.
REQ-007 wr_resp_valid / wr_resp_ready / wr_resp_code  out/in/out  1/1/2  write response; code 00 OKAY, 01 NACK, 10 TIMEOUT.
REQ-008 rd_resp_valid / rd_resp_ready / rd_resp_code / rd_resp_data  out/in/out/out  1/1/2/8  read response and read byte.
REQ-009 m_cmd  output  CMD_W  command to the I2C master; held stable from ISSUE through WAIT.
REQ-010 m_cmd_valid, m_trigger  output  1 each  single-cycle pulses to the master.
REQ-011 m_busy, m_done, m_ack_err  input  1 each  master busy level; completion pulse; NACK flag, sampled with m_done.
REQ-012 m_rdata  input  8  read byte, sampled with m_done.

Function
REQ-013 States SHALL be IDLE, ISSUE, TRIG, WAIT, RESP.
REQ-014 IDLE: wr_req_ready / rd_req_ready SHALL be high only for the granted requester, and only while m_busy=0.
REQ-015 Grant SHALL be round-robin: on simultaneous valids, the requester not served last wins; after reset, write wins.
REQ-016 A handshake (valid & ready) SHALL register the command into m_cmd, latch the grant, and move to ISSUE.
REQ-017 A write requester's command SHALL have bit 16 forced to 0; a read requester's, to 1.
REQ-018 ISSUE SHALL assert m_cmd_valid for exactly one cycle, then move to TRIG.
REQ-019 TRIG SHALL assert m_trigger for exactly one cycle, clear the timeout counter, then move to WAIT.
REQ-020 WAIT SHALL increment the timeout counter each cycle.
REQ-021 WAIT SHALL capture m_ack_err (code 01 if set, else 00) and m_rdata on m_done, then move to RESP.
REQ-022 When the counter reaches TIMEOUT_CYC-1 without m_done, WAIT SHALL set code 10 and data 0x00, then move to RESP.
REQ-023 If m_done and timeout coincide, m_done SHALL take precedence.
REQ-024 RESP SHALL hold *_resp_valid high for the granted requester only, with code and data stable, until *_resp_ready=1.
REQ-025 On the RESP handshake the FSM SHALL return to IDLE and update the round-robin pointer; a new grant is possible the next cycle.
REQ-026 rd_resp_data SHALL be 0x00 on any non-OKAY code; wr_resp has no data.
REQ-027 m_done outside WAIT SHALL be ignored.
REQ-028 Request valids SHALL be ignored outside IDLE; ready stays low.
REQ-029 Minimum latency from request handshake to resp_valid SHALL be 4 cycles (ISSUE, TRIG, WAIT with m_done, RESP).

Reset
REQ-030 On resetn=0, asynchronously: state IDLE; all valid, ready, pulse and response outputs 0; m_cmd 0; counter 0; round-robin pointer "write next".
REQ-031 Reset mid-transaction SHALL abandon the transaction without issuing a response.
REQ-032 After reset release, the first grant SHALL be no earlier than the first clk edge following deassertion.

Structure
REQ-033 Package i2c_sched_pkg SHALL hold: the state enum, the resp_code typedef and its constants (OKAY, NACK, TIMEOUT), and the command field offsets.
REQ-034 Two-requester round-robin arbitration SHALL be a sub-module, i2c_rr_arb2 (req[1:0], ack, grant[1:0]).
REQ-035 The remaining logic (FSM, timeout counter, response registers) SHALL stay in i2c_cmd_scheduler.

Verification
REQ-036 Write req cmd 0xA0_10_5A, m_done at WAIT+3, ack_err=0 -> m_cmd 0xA0105A, one m_cmd_valid then one m_trigger pulse, wr_resp code 00.
REQ-037 Read req cmd 0xA1_20_00, m_done with m_rdata 0x3C -> rd_resp_code 00, rd_resp_data 0x3C.
REQ-038 Both valids every cycle for 4 transactions from reset -> grants W, R, W, R.
REQ-039 Write with m_ack_err=1 at m_done -> code 01; read with no m_done -> code 10 exactly TIMEOUT_CYC cycles after WAIT entry (TIMEOUT_CYC=16), data 0x00.
REQ-040 m_busy=1 in IDLE with a pending request -> ready held low until m_busy drops.
REQ-041 resp_ready held low 10 cycles -> response held stable.
REQ-042 resetn pulsed in WAIT -> all outputs 0 and no response.

Source files
------------

// File: rtl/i2c_cmd_scheduler_pkg.sv
// i2c_sched_pkg: shared types and command-field offsets for the I2C command scheduler.
package i2c_sched_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_TRIG  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;
    typedef logic [1:0] resp_code_t;
    localparam resp_code_t RESP_OKAY    = 2'b00;
    localparam resp_code_t RESP_NACK    = 2'b01;
    localparam resp_code_t RESP_TIMEOUT = 2'b10;
    localparam int CMD_DEV_LSB   = 17;
    localparam int CMD_RW_BIT    = 16;
    localparam int CMD_REG_LSB   = 8;
    localparam int CMD_WDATA_LSB = 0;
endpackage

// File: rtl/i2c_cmd_scheduler_if.sv
// i2c_cmd_scheduler_if: requester handshakes, responses and I2C master strobes.
interface i2c_cmd_scheduler_if #(parameter int CMD_W = 24);
    logic             wr_req_valid;
    logic             wr_req_ready;
    logic [CMD_W-1:0] wr_req_cmd;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [CMD_W-1:0] rd_req_cmd;
    logic             wr_resp_valid;
    logic             wr_resp_ready;
    logic [1:0]       wr_resp_code;
    logic             rd_resp_valid;
    logic             rd_resp_ready;
    logic [1:0]       rd_resp_code;
    logic [7:0]       rd_resp_data;
    logic [CMD_W-1:0] m_cmd;
    logic             m_cmd_valid;
    logic             m_trigger;
    logic             m_busy;
    logic             m_done;
    logic             m_ack_err;
    logic [7:0]       m_rdata;
    modport slave (
        input  wr_req_valid, wr_req_cmd, rd_req_valid, rd_req_cmd,
               wr_resp_ready, rd_resp_ready, m_busy, m_done, m_ack_err, m_rdata,
        output wr_req_ready, rd_req_ready, wr_resp_valid, wr_resp_code,
               rd_resp_valid, rd_resp_code, rd_resp_data, m_cmd, m_cmd_valid, m_trigger
    );
    modport master (
        output wr_req_valid, wr_req_cmd, rd_req_valid, rd_req_cmd,
               wr_resp_ready, rd_resp_ready, m_busy, m_done, m_ack_err, m_rdata,
        input  wr_req_ready, rd_req_ready, wr_resp_valid, wr_resp_code,
               rd_resp_valid, rd_resp_code, rd_resp_data, m_cmd, m_cmd_valid, m_trigger
    );
endinterface

// File: rtl/i2c_cmd_scheduler_rr_arb2.sv
// i2c_rr_arb2: two-requester round-robin arbiter; the pointer moves past whoever is granted on ack.
module i2c_rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_req,
    input  logic       i_ack,
    output logic [1:0] o_grant
);
    logic r_ptr;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_ptr <= 1'b0;
        else if (i_ack) r_ptr <= o_grant[0];
    end
    always_comb o_grant = (&i_req) ? (r_ptr ? 2'b10 : 2'b01) : i_req;
endmodule

// File: rtl/i2c_cmd_scheduler.sv
// i2c_cmd_scheduler: arbitrates write/read requesters onto one I2C master and returns a coded response.
module i2c_cmd_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int TIMEOUT_CYC = 4000000,
    parameter int CMD_W       = 24
) (
    input logic                  clk,
    input logic                  resetn,
    i2c_cmd_scheduler_if.slave   io_bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    state_e           r_state;
    logic             r_run;
    logic             r_sel_rd;
    logic [CMD_W-1:0] r_cmd;
    logic [CNT_W-1:0] r_cnt;
    resp_code_t       r_code;
    logic [7:0]       r_data;
    logic [1:0]       w_req;
    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_take;
    logic             w_hs;
    logic             w_resp_hs;
    logic             w_tmo;
    logic [CMD_W-1:0] w_cmd_in;
    assign w_idle    = r_state == ST_IDLE;
    // outside IDLE the in-flight owner is presented so the pointer moves past it on ack
    assign w_req     = w_idle ? {io_bus.rd_req_valid, io_bus.wr_req_valid} : {r_sel_rd, ~r_sel_rd};
    assign w_take    = w_idle & r_run & ~io_bus.m_busy;
    assign w_hs      = w_take & (|w_req);
    assign w_resp_hs = (r_state == ST_RESP) & (r_sel_rd ? io_bus.rd_resp_ready : io_bus.wr_resp_ready);
    assign w_tmo     = r_cnt == CNT_W'(TIMEOUT_CYC - 1);
    i2c_rr_arb2 u_arb (
        .clk     (clk),
        .resetn  (resetn),
        .i_req   (w_req),
        .i_ack   (w_resp_hs),
        .o_grant (w_grant)
    );
    always_comb begin
        w_cmd_in = w_grant[1] ? io_bus.rd_req_cmd : io_bus.wr_req_cmd;
        w_cmd_in[CMD_RW_BIT] = w_grant[1];
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_run    <= 1'b0;
            r_sel_rd <= 1'b0;
            r_cmd    <= '0;
            r_cnt    <= '0;
            r_code   <= RESP_OKAY;
            r_data   <= 8'h00;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_IDLE: if (w_hs) begin
                    r_sel_rd <= w_grant[1];
                    r_cmd    <= w_cmd_in;
                    r_state  <= ST_ISSUE;
                end
                ST_ISSUE: r_state <= ST_TRIG;
                ST_TRIG: begin
                    r_cnt   <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (io_bus.m_done) begin
                        r_code  <= io_bus.m_ack_err ? RESP_NACK : RESP_OKAY;
                        r_data  <= (io_bus.m_ack_err | ~r_sel_rd) ? 8'h00 : io_bus.m_rdata;
                        r_state <= ST_RESP;
                    end else if (w_tmo) begin
                        r_code  <= RESP_TIMEOUT;
                        r_data  <= 8'h00;
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: if (w_resp_hs) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign io_bus.wr_req_ready  = w_take & w_grant[0];
    assign io_bus.rd_req_ready  = w_take & w_grant[1];
    assign io_bus.m_cmd         = r_cmd;
    assign io_bus.m_cmd_valid   = r_state == ST_ISSUE;
    assign io_bus.m_trigger     = r_state == ST_TRIG;
    assign io_bus.wr_resp_valid = (r_state == ST_RESP) & ~r_sel_rd;
    assign io_bus.rd_resp_valid = (r_state == ST_RESP) & r_sel_rd;
    assign io_bus.wr_resp_code  = r_code;
    assign io_bus.rd_resp_code  = r_code;
    assign io_bus.rd_resp_data  = r_data;
endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// tb_i2c_cmd_scheduler: vector table, corner sequences and randomized transactions against a transaction-level model.
module tb_i2c_cmd_scheduler;
    import i2c_sched_pkg::*;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;
    i2c_cmd_scheduler_if #(.CMD_W(24)) bus ();
    i2c_cmd_scheduler #(.TIMEOUT_CYC(TO), .CMD_W(24)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io_bus (bus.slave)
    );
    typedef struct {
        bit          rst;
        bit          wv;
        bit          rv;
        logic [23:0] wc;
        logic [23:0] rc;
        int          busy;
        int          dly;
        bit          ack;
        logic [7:0]  rdata;
        int          hold;
        bit          exp_rd;
        logic [23:0] exp_cmd;
        logic [1:0]  exp_code;
        logic [7:0]  exp_data;
    } vec_t;
    vec_t tbl[12];
    vec_t v;
    int   total = 0;
    int   bad = 0;
    bit   ptr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.wr_req_valid = 0; bus.rd_req_valid = 0;
        bus.wr_req_cmd = 0;   bus.rd_req_cmd = 0;
        bus.wr_resp_ready = 0; bus.rd_resp_ready = 0;
        bus.m_busy = 0; bus.m_done = 0; bus.m_ack_err = 0; bus.m_rdata = 0;
    endtask

    task automatic do_reset;
        resetn = 0;
        bus.wr_req_valid = 1; bus.rd_req_valid = 1;
        #2;
        chk("reset_ctrl", {bus.wr_req_ready, bus.rd_req_ready, bus.wr_resp_valid, bus.rd_resp_valid,
            bus.m_cmd_valid, bus.m_trigger, bus.wr_resp_code, bus.rd_resp_code, bus.rd_resp_data}, 0);
        chk("reset_m_cmd", bus.m_cmd, 0);
        clear_inputs();
        step(); step();
        resetn = 1;
        step();
    endtask

    function automatic vec_t mk(bit rst, bit wv, bit rv, logic [23:0] wc, logic [23:0] rc, int busy,
                                int dly, bit ack, logic [7:0] rdata, int hold, bit exp_rd,
                                logic [23:0] exp_cmd, logic [1:0] exp_code, logic [7:0] exp_data);
        vec_t r;
        r.rst = rst; r.wv = wv; r.rv = rv; r.wc = wc; r.rc = rc; r.busy = busy; r.dly = dly;
        r.ack = ack; r.rdata = rdata; r.hold = hold; r.exp_rd = exp_rd; r.exp_cmd = exp_cmd;
        r.exp_code = exp_code; r.exp_data = exp_data;
        return r;
    endfunction

    task automatic run_txn(input vec_t t);
        int cnt;
        logic [1:0] code;
        logic [7:0] data;
        bus.wr_req_valid = t.wv; bus.rd_req_valid = t.rv;
        bus.wr_req_cmd = t.wc;   bus.rd_req_cmd = t.rc;
        for (int i = 0; i < t.busy; i++) begin
            bus.m_busy = 1;
            #1;
            chk("ready_while_busy", {bus.rd_req_ready, bus.wr_req_ready}, 0);
            step();
        end
        bus.m_busy = 0;
        #1;
        chk("grant", {bus.rd_req_ready, bus.wr_req_ready}, t.exp_rd ? 2'b10 : 2'b01);
        step();
        chk("issue", {bus.m_cmd_valid, bus.m_trigger, bus.rd_req_ready, bus.wr_req_ready}, 4'b1000);
        chk("m_cmd", bus.m_cmd, t.exp_cmd);
        step();
        chk("trig", {bus.m_cmd_valid, bus.m_trigger, bus.rd_req_ready, bus.wr_req_ready}, 4'b0100);
        step();
        chk("wait0", {bus.m_cmd_valid, bus.m_trigger, bus.rd_req_ready, bus.wr_req_ready}, 4'b0000);
        cnt = 0;
        while (!(bus.wr_resp_valid || bus.rd_resp_valid) && cnt < TO + 8) begin
            if (cnt == t.dly) begin
                bus.m_done = 1; bus.m_ack_err = t.ack; bus.m_rdata = t.rdata;
            end
            step();
            bus.m_done = 0; bus.m_ack_err = 0; bus.m_rdata = 0;
            cnt++;
        end
        chk("latency", cnt, t.dly < TO ? t.dly + 1 : TO);
        chk("m_cmd_held", bus.m_cmd, t.exp_cmd);
        for (int i = 0; i <= t.hold; i++) begin
            code = t.exp_rd ? bus.rd_resp_code : bus.wr_resp_code;
            data = t.exp_rd ? bus.rd_resp_data : 8'h00;
            chk("resp", {bus.rd_resp_valid, bus.wr_resp_valid, bus.rd_req_ready, bus.wr_req_ready, code, data},
                {t.exp_rd, !t.exp_rd, 2'b00, t.exp_code, t.exp_data});
            if (i < t.hold) begin
                if (i == 0) begin
                    bus.m_done = 1; bus.m_ack_err = 1; bus.m_rdata = 8'hEE;
                end
                step();
                bus.m_done = 0; bus.m_ack_err = 0; bus.m_rdata = 0;
            end
        end
        bus.wr_resp_ready = !t.exp_rd; bus.rd_resp_ready = t.exp_rd;
        bus.wr_req_valid = 0; bus.rd_req_valid = 0;
        step();
        bus.wr_resp_ready = 0; bus.rd_resp_ready = 0;
        chk("resp_done", {bus.rd_resp_valid, bus.wr_resp_valid}, 0);
    endtask

    initial begin
        clear_inputs();
        tbl[0]  = mk(1, 1, 1, 24'hA0105A, 24'hA12000, 0, 3,  0, 8'h3C, 0, 0, 24'hA0105A, 2'b00, 8'h00);
        tbl[1]  = mk(0, 1, 1, 24'hA0105A, 24'hA12000, 0, 0,  0, 8'h3C, 0, 1, 24'hA12000, 2'b00, 8'h3C);
        tbl[2]  = mk(0, 1, 1, 24'hA0105A, 24'hA12000, 0, 2,  0, 8'h3C, 0, 0, 24'hA0105A, 2'b00, 8'h00);
        tbl[3]  = mk(0, 1, 1, 24'hA0105A, 24'hA12000, 0, 1,  0, 8'h3C, 0, 1, 24'hA12000, 2'b00, 8'h3C);
        tbl[4]  = mk(0, 1, 0, 24'hA0105A, 24'h000000, 0, 3,  0, 8'h00, 0, 0, 24'hA0105A, 2'b00, 8'h00);
        tbl[5]  = mk(0, 0, 1, 24'h000000, 24'hA12000, 0, 0,  0, 8'h3C, 0, 1, 24'hA12000, 2'b00, 8'h3C);
        tbl[6]  = mk(0, 1, 0, 24'hB0C0D0, 24'h000000, 0, 2,  1, 8'h55, 0, 0, 24'hB0C0D0, 2'b01, 8'h00);
        tbl[7]  = mk(0, 0, 1, 24'h000000, 24'h5A3301, 0, 99, 0, 8'h00, 0, 1, 24'h5B3301, 2'b10, 8'h00);
        tbl[8]  = mk(0, 1, 0, 24'hA1FFEE, 24'h000000, 0, 15, 1, 8'h00, 0, 0, 24'hA0FFEE, 2'b01, 8'h00);
        tbl[9]  = mk(0, 0, 1, 24'h000000, 24'h9020AB, 5, 5,  0, 8'h77, 10, 1, 24'h9120AB, 2'b00, 8'h77);
        tbl[10] = mk(0, 0, 1, 24'h000000, 24'h4410CC, 0, 1,  1, 8'hFF, 2, 1, 24'h4510CC, 2'b01, 8'h00);
        tbl[11] = mk(0, 1, 0, 24'h123456, 24'h000000, 0, 4,  0, 8'h00, 0, 0, 24'h123456, 2'b00, 8'h00);
        for (int k = 0; k < 12; k++) begin
            if (tbl[k].rst) do_reset();
            run_txn(tbl[k]);
        end
        // abandon a read in WAIT: no response afterwards, pointer back to write-first
        bus.rd_req_valid = 1; bus.rd_req_cmd = 24'h334455;
        step(); step(); step(); step();
        bus.rd_req_valid = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.m_done = 1;
            #1;
            chk("no_resp_after_reset", {bus.rd_resp_valid, bus.wr_resp_valid, bus.m_cmd_valid, bus.m_trigger}, 0);
            step();
        end
        bus.m_done = 0;
        run_txn(mk(0, 1, 1, 24'h0F0F0F, 24'h707070, 0, 0, 0, 8'h11, 0, 0, 24'h0E0F0F, 2'b00, 8'h00));
        do_reset();
        ptr = 0;
        for (int n = 0; n < 40; n++) begin
            v.rst = 0;
            v.wv = 1'($urandom_range(0, 1));
            v.rv = v.wv ? 1'($urandom_range(0, 1)) : 1'b1;
            v.wc = 24'($urandom);
            v.rc = 24'($urandom);
            v.busy = $urandom_range(0, 2);
            v.dly = $urandom_range(0, 20);
            v.ack = 1'($urandom_range(0, 1));
            v.rdata = 8'($urandom);
            v.hold = $urandom_range(0, 3);
            v.exp_rd = (v.wv && v.rv) ? ptr : v.rv;
            v.exp_cmd = v.exp_rd ? v.rc : v.wc;
            v.exp_cmd[CMD_RW_BIT] = v.exp_rd;
            v.exp_code = v.dly >= TO ? RESP_TIMEOUT : (v.ack ? RESP_NACK : RESP_OKAY);
            v.exp_data = (v.exp_rd && v.exp_code == RESP_OKAY) ? v.rdata : 8'h00;
            run_txn(v);
            ptr = !v.exp_rd;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
